// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop iterated
// over WIDTH cycles, with start/busy/done handshake and signed-overflow flag.
module somador_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic             accept;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign accept    = start && (state_q != SHIFT);
    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_nxt = maj(opa_q[0], opb_q[0], carry_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = (count_q == LAST) ? DONE : SHIFT;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath: load on accept, one bit per SHIFT cycle, publish on the last bit
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        count_d = count_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        if (accept) begin
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            count_d = '0;
        end else if (state_q == SHIFT) begin
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            carry_d = carry_nxt;
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == PENULT) c_msb_d = carry_nxt;
            if (count_q == LAST) begin
                s_d   = {sum_bit, res_q[WIDTH-1:1]};
                co_d  = carry_nxt;
                ovf_d = carry_nxt ^ c_msb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            count_q <= count_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s   = s_q;
    assign co  = co_q;
    assign ovf = ovf_q;

endmodule
